// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// control-group opcodes and the instruction decode helper.
package instr_fetch_unit_pkg;

   localparam int IR_W = 24;

   localparam logic [3:0]      CTRL_GRP = 4'h1;
   localparam logic [7:0]      OP_JMP   = 8'd0;
   localparam logic [7:0]      OP_JZE   = 8'd1;
   localparam logic [7:0]      OP_JNE   = 8'd2;
   localparam logic [7:0]      OP_JCY   = 8'd3;
   localparam logic [7:0]      OP_RET   = 8'd4;
   localparam logic [7:0]      OP_BSR   = 8'd5;
   localparam logic [IR_W-1:0] RET_ALT  = 24'h080005;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_ISSUE,
      ST_RESOLVE
   } state_t;

   typedef enum logic [2:0] {
      CF_SEQ,
      CF_JMP,
      CF_JZE,
      CF_JNE,
      CF_JCY,
      CF_RET,
      CF_BSR
   } cflow_t;

   // RET_ALT lives outside the control group but still behaves as a return.
   function automatic cflow_t decode_cflow(input logic [IR_W-1:0] word);
      cflow_t cf;
      cf = CF_SEQ;
      if (word == RET_ALT) begin
         cf = CF_RET;
      end else if (word[23:20] == CTRL_GRP) begin
         case (word[19:12])
            OP_JMP:  cf = CF_JMP;
            OP_JZE:  cf = CF_JZE;
            OP_JNE:  cf = CF_JNE;
            OP_JCY:  cf = CF_JCY;
            OP_RET:  cf = CF_RET;
            OP_BSR:  cf = CF_BSR;
            default: cf = CF_SEQ;
         endcase
      end
      return cf;
   endfunction

   function automatic logic is_cond(input cflow_t cf);
      return (cf == CF_JZE) || (cf == CF_JNE) || (cf == CF_JCY);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_ret_stack.sv
// Return-address LIFO. Push on full and pop on empty are ignored here;
// the caller decides what those cases mean.
module ret_stack #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_top,
   output logic              o_full,
   output logic              o_empty
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SPW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [SPW-1:0]    r_sp;
   logic [AW-1:0]     w_top_idx;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_sp == SPW'(DEPTH));
   assign o_empty   = (r_sp == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign w_top_idx = AW'(r_sp - SPW'(1));
   assign o_top     = r_mem[w_top_idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sp <= '0;
      end else if (w_do_push) begin
         r_sp <= r_sp + SPW'(1);
      end else if (w_do_pop) begin
         r_sp <= r_sp - SPW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_sp[AW-1:0]] <= i_data;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words from program memory,
// hands them to decode and resolves control flow with a return stack.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | first cycle after reset release
// FETCH    | pm_req high for one cycle, pm_addr = pc
// WAIT     | waiting for pm_valid, then latch word into ir
// ISSUE    | ir_valid high until ir_ready; unconditional flow resolved
// RESOLVE  | conditional jump waiting for flags_stable
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int PC_W        = 12,
   parameter int STACK_DEPTH = 8
) (
   input  logic            clk,
   input  logic            reset,
   output logic            pm_req,
   output logic [PC_W-1:0] pm_addr,
   input  logic [IR_W-1:0] pm_rdata,
   input  logic            pm_valid,
   output logic [IR_W-1:0] ir,
   output logic            ir_valid,
   input  logic            ir_ready,
   input  logic            z_flag,
   input  logic            cy_flag,
   input  logic            flags_stable,
   output logic            stack_err,
   output logic [PC_W-1:0] pc_out
);

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [IR_W-1:0] r_ir;
   logic            r_ir_valid;
   logic            r_pm_req;
   logic [PC_W-1:0] r_pm_addr;
   logic            r_stack_err;

   cflow_t          w_cf;
   logic [PC_W-1:0] w_pc_inc;
   logic [PC_W-1:0] w_target;
   logic [PC_W-1:0] w_pc_issue;
   logic [PC_W-1:0] w_pc_resolve;
   logic [PC_W-1:0] w_top;
   logic            w_full;
   logic            w_empty;
   logic            w_handshake;
   logic            w_push;
   logic            w_pop;
   logic            w_taken;
   logic            w_stack_fault;

   assign w_cf        = decode_cflow(r_ir);
   assign w_pc_inc    = r_pc + PC_W'(1);
   assign w_target    = r_ir[PC_W-1:0];
   assign w_handshake = (r_state == ST_ISSUE) && ir_ready;
   assign w_push      = w_handshake && (w_cf == CF_BSR);
   assign w_pop       = w_handshake && (w_cf == CF_RET);

   assign w_stack_fault = ((w_cf == CF_BSR) && w_full) ||
                          ((w_cf == CF_RET) && w_empty);

   ret_stack #(
      .DATA_W (PC_W),
      .DEPTH  (STACK_DEPTH)
   ) u_ret_stack (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_pc_inc),
      .o_top   (w_top),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_pc_issue = w_pc_inc;
      case (w_cf)
         CF_JMP, CF_BSR: w_pc_issue = w_target;
         CF_RET:         w_pc_issue = w_empty ? '0 : w_top;
         default:        w_pc_issue = w_pc_inc;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (w_cf)
         CF_JZE:  w_taken = z_flag;
         CF_JNE:  w_taken = !z_flag;
         CF_JCY:  w_taken = cy_flag;
         default: w_taken = 1'b0;
      endcase
   end

   assign w_pc_resolve = w_taken ? w_target : w_pc_inc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_pc        <= '0;
         r_ir        <= '0;
         r_ir_valid  <= 1'b0;
         r_pm_req    <= 1'b0;
         r_pm_addr   <= '0;
         r_stack_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_pm_req  <= 1'b1;
               r_pm_addr <= r_pc;
               r_state   <= ST_FETCH;
            end
            ST_FETCH: begin
               r_pm_req <= 1'b0;
               r_state  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (pm_valid) begin
                  r_ir       <= pm_rdata;
                  r_ir_valid <= 1'b1;
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (ir_ready) begin
                  r_ir_valid <= 1'b0;
                  if (is_cond(w_cf)) begin
                     r_state <= ST_RESOLVE;
                  end else begin
                     r_pc      <= w_pc_issue;
                     r_pm_addr <= w_pc_issue;
                     r_pm_req  <= 1'b1;
                     r_state   <= ST_FETCH;
                     if (w_stack_fault) begin
                        r_stack_err <= 1'b1;
                     end
                  end
               end
            end
            ST_RESOLVE: begin
               if (flags_stable) begin
                  r_pc      <= w_pc_resolve;
                  r_pm_addr <= w_pc_resolve;
                  r_pm_req  <= 1'b1;
                  r_state   <= ST_FETCH;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_pm_req <= 1'b0;
            end
         endcase
      end
   end

   assign pm_req    = r_pm_req;
   assign pm_addr   = r_pm_addr;
   assign ir        = r_ir;
   assign ir_valid  = r_ir_valid;
   assign stack_err = r_stack_err;
   assign pc_out    = r_pc;

endmodule
